// File: rtl/fcvt_f2i_seq.sv
// Sequential float32 -> int32/uint32 converter (FCVT.W.S / FCVT.WU.S).
// Uses an iterative significand aligner, then round/saturate and RISC-V fflags.
module fcvt_f2i_seq #(
   parameter int SHIFT_STEP = 8
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        flush,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [31:0] req_src,
   input  logic [2:0]  req_rm,
   input  logic        req_unsigned,
   input  logic [4:0]  req_rd,
   input  logic [2:0]  frm_csr,
   output logic        resp_valid,
   input  logic        resp_ready,
   output logic [31:0] resp_data,
   output logic [4:0]  resp_rd,
   output logic [4:0]  resp_fflags,
   output logic        resp_illegal,
   output logic        busy
);

   typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_ROUND, ST_DONE} state_t;
   localparam logic [4:0] LP_STEP = 5'(SHIFT_STEP);

   state_t      r_state;
   logic        r_sign;
   logic        r_unsigned;
   logic [2:0]  r_rm;
   logic        r_left;
   logic [4:0]  r_rem;
   logic [55:0] r_acc;
   logic        r_sticky;
   logic [31:0] r_resp_data;
   logic [4:0]  r_resp_rd;
   logic [4:0]  r_resp_fflags;
   logic        r_resp_illegal;

   logic [7:0]  w_exp;
   logic [22:0] w_man;
   logic [2:0]  w_rm;
   logic        w_illegal;
   logic        w_nan;
   logic        w_big;
   logic        w_left;
   logic [7:0]  w_ldiff;
   logic [7:0]  w_rdiff;
   logic [4:0]  w_shamt;
   logic [4:0]  w_step;
   logic [55:0] w_mask;
   logic        w_lost;
   logic [31:0] w_int;
   logic        w_g;
   logic        w_x;
   logic        w_inc;
   logic [32:0] w_mag;
   logic [31:0] w_res;
   logic        w_nv;
   logic        w_nx;

   assign w_exp     = req_src[30:23];
   assign w_man     = req_src[22:0];
   assign w_rm      = (req_rm == 3'b111) ? frm_csr : req_rm;
   assign w_illegal = (w_rm >= 3'd5);
   assign w_nan     = (&w_exp) & (|w_man);
   assign w_big     = (w_exp >= 8'd159);
   assign w_left    = (w_exp >= 8'd127);
   assign w_ldiff   = w_exp - 8'd127;
   assign w_rdiff   = 8'd127 - w_exp;
   // Right shifts beyond 25 only feed the sticky bit, so they are clamped.
   assign w_shamt   = w_left ? w_ldiff[4:0] : ((w_rdiff > 8'd25) ? 5'd25 : w_rdiff[4:0]);

   assign w_step = (r_rem > LP_STEP) ? LP_STEP : r_rem;
   assign w_mask = (56'd1 << w_step) - 56'd1;
   assign w_lost = |(r_acc & w_mask);

   assign w_int = r_acc[55:24];
   assign w_g   = r_acc[23];
   assign w_x   = (|r_acc[22:0]) | r_sticky;

   always_comb begin
      w_inc = 1'b0;
      case (r_rm)
         3'b000:  w_inc = w_g & (w_x | w_int[0]);
         3'b001:  w_inc = 1'b0;
         3'b010:  w_inc = r_sign & (w_g | w_x);
         3'b011:  w_inc = ~r_sign & (w_g | w_x);
         3'b100:  w_inc = w_g;
         default: w_inc = 1'b0;
      endcase
   end

   assign w_mag = {1'b0, w_int} + {32'b0, w_inc};

   always_comb begin
      w_res = w_mag[31:0];
      w_nv  = 1'b0;
      if (r_unsigned) begin
         if (r_sign) begin
            w_res = 32'h0000_0000;
            w_nv  = |w_mag;
         end else if (w_mag[32]) begin
            w_res = 32'hFFFF_FFFF;
            w_nv  = 1'b1;
         end
      end else if (r_sign) begin
         if (w_mag > 33'h0_8000_0000) begin
            w_res = 32'h8000_0000;
            w_nv  = 1'b1;
         end else begin
            w_res = -w_mag[31:0];
         end
      end else if (w_mag > 33'h0_7FFF_FFFF) begin
         w_res = 32'h7FFF_FFFF;
         w_nv  = 1'b1;
      end
   end

   assign w_nx = (w_g | w_x) & ~w_nv;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state        <= ST_IDLE;
         r_sign         <= 1'b0;
         r_unsigned     <= 1'b0;
         r_rm           <= 3'b000;
         r_left         <= 1'b0;
         r_rem          <= 5'd0;
         r_acc          <= 56'd0;
         r_sticky       <= 1'b0;
         r_resp_data    <= 32'd0;
         r_resp_rd      <= 5'd0;
         r_resp_fflags  <= 5'd0;
         r_resp_illegal <= 1'b0;
      end else if (flush) begin
         r_state <= ST_IDLE;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (req_valid) begin
                  r_sign     <= req_src[31];
                  r_unsigned <= req_unsigned;
                  r_rm       <= w_rm;
                  r_resp_rd  <= req_rd;
                  r_left     <= w_left;
                  r_rem      <= w_shamt;
                  r_acc      <= {31'b0, |w_exp, w_man, 1'b0};
                  r_sticky   <= 1'b0;
                  if (w_illegal) begin
                     r_resp_data    <= 32'd0;
                     r_resp_fflags  <= 5'd0;
                     r_resp_illegal <= 1'b1;
                     r_state        <= ST_DONE;
                  end else if (w_nan || w_big) begin
                     // NaN saturates like a positive overflow.
                     if (req_src[31] && !w_nan)
                        r_resp_data <= req_unsigned ? 32'h0000_0000 : 32'h8000_0000;
                     else
                        r_resp_data <= req_unsigned ? 32'hFFFF_FFFF : 32'h7FFF_FFFF;
                     r_resp_fflags  <= 5'b10000;
                     r_resp_illegal <= 1'b0;
                     r_state        <= ST_DONE;
                  end else begin
                     r_state <= (w_shamt == 5'd0) ? ST_ROUND : ST_SHIFT;
                  end
               end
            end
            ST_SHIFT: begin
               r_acc    <= r_left ? (r_acc << w_step) : (r_acc >> w_step);
               r_sticky <= r_sticky | (~r_left & w_lost);
               r_rem    <= r_rem - w_step;
               if (r_rem == w_step)
                  r_state <= ST_ROUND;
            end
            ST_ROUND: begin
               r_resp_data    <= w_res;
               r_resp_fflags  <= {w_nv, 3'b000, w_nx};
               r_resp_illegal <= 1'b0;
               r_state        <= ST_DONE;
            end
            ST_DONE: begin
               if (resp_ready)
                  r_state <= ST_IDLE;
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign req_ready    = (r_state == ST_IDLE) & ~flush;
   assign busy         = (r_state != ST_IDLE);
   assign resp_valid   = (r_state == ST_DONE);
   assign resp_data    = r_resp_data;
   assign resp_rd      = r_resp_rd;
   assign resp_fflags  = r_resp_fflags;
   assign resp_illegal = r_resp_illegal;

endmodule

// File: doc/fcvt_f2i_seq.md
Name: fcvt_f2i_seq

Overview:
Multi-cycle sequencer for the FPU's FCVT.W.S / FCVT.WU.S path. It accepts one conversion request from FPU issue over a valid/ready handshake and resolves dynamic rounding against frm. It aligns the significand with an iterative shifter (SHIFT_STEP bits/cycle), then rounds, saturates and produces RISC-V fflags. The result is held until the writeback stage accepts it. The block replaces single-cycle wide-shift conversion on the timing-critical path.

Parameters:
SHIFT_STEP, 8, maximum shift distance per SHIFT cycle (1..31)

Ports:
clk  in  1  clock
reset_n  in  1  asynchronous active-low reset
flush  in  1  synchronous kill of in-flight op
req_valid  in  1  request valid
req_ready  out  1  = (state==IDLE) & ~flush
req_src  in  32  IEEE-754 single operand
req_rm  in  3  instruction rm; 111 = dynamic
req_unsigned  in  1  1 = FCVT.WU.S
req_rd  in  5  destination tag
frm_csr  in  3  current frm CSR
resp_valid  out  1  result valid
resp_ready  in  1  consumer accept
resp_data  out  32  integer result
resp_rd  out  5  captured req_rd
resp_fflags  out  5  {NV,DZ,OF,UF,NX}; DZ/OF/UF always 0
resp_illegal  out  1  resolved rm invalid
busy  out  1  state != IDLE

Behaviour:
- Reset (async, reset_n=0):
  - state=IDLE.
  - resp_valid, resp_data, resp_rd, resp_fflags and resp_illegal are all 0.
- FSM states: IDLE, SHIFT, ROUND, DONE.
- Accept: req_valid & req_ready at a rising edge. Capture sign, exp, man, unsigned flag, rd, and the resolved rm (frm_csr if req_rm==111, else req_rm).
- Datapath register acc[55:0]:
  - Integer part is acc[55:24]; fraction is acc[23:0].
  - Initial value: {31'b0, exp!=0, man, 1'b0}.
  - e = exp−127.
  - Remaining shift: left e if e≥0; right min(127−exp, 25) if e<0 (exp=0 uses 25).
  - Bits shifted out on the right OR into a sticky flag.
- Special classes at accept go IDLE→DONE; resp_valid is high the cycle after accept:
  - Resolved rm ∈ {101,110,111}: resp_illegal=1, data 0, fflags 0.
  - NaN: signed 0x7FFFFFFF, unsigned 0xFFFFFFFF, NV.
  - +inf or e≥32 positive: signed 0x7FFFFFFF, unsigned 0xFFFFFFFF, NV.
  - −inf or e≥32 negative: signed 0x80000000, unsigned 0, NV.
- Normal path:
  - Remaining shift 0: IDLE→ROUND.
  - Otherwise IDLE→SHIFT. Each SHIFT cycle shifts by min(remaining, SHIFT_STEP); when remaining reaches 0, go to ROUND.
  - k = ceil(shift/SHIFT_STEP).
  - Latency is accept + k + 2 cycles to resp_valid.
- ROUND (one cycle):
  - int=acc[55:24], G=acc[23], X=|acc[22:0] | sticky.
  - Increment by rm:
    - RNE: G&(X|int[0])
    - RTZ: 0
    - RDN: sign&(G|X)
    - RUP: ~sign&(G|X)
    - RMM: G
  - mag = int + inc, 33 bits.
- Saturation:
  - Signed, positive: mag>0x7FFFFFFF → 0x7FFFFFFF, NV.
  - Signed, negative: mag>0x80000000 → 0x80000000, NV; else −mag.
  - Unsigned, negative: mag≠0 → 0, NV; mag==0 → 0.
  - Unsigned, positive: mag>0xFFFFFFFF → 0xFFFFFFFF, NV.
  - NX = (G|X) & ~NV.
- DONE:
  - resp_valid=1; all resp_* held stable until resp_valid&resp_ready, then IDLE.
  - No same-cycle re-accept.
- flush: any state→IDLE at the next edge and resp_valid deasserts. flush has priority over resp_ready and over req_valid (no accept while flush=1).
- frm_csr is sampled only at accept; later changes do not affect an in-flight op.

Test Plan:
1. 0x40490FDB (π), rm=000, signed → 0x00000003, fflags 0x01; resp_valid 3 cycles after accept (k=1).
2. 0x40200000 (2.5) → by rm:
   - RNE → 2
   - RUP → 3
   - RMM → 3
   - RTZ → 2
   - All with fflags 0x01.
   - 0xC0200000 with RDN, signed → 0xFFFFFFFD.
3. 0x4F000000 (2^31):
   - Signed → 0x7FFFFFFF, fflags 0x10.
   - Unsigned → 0x80000000, fflags 0x00.
   - 0xBF800000 (−1.0) unsigned → 0, fflags 0x10.
4. 0x7FC00000 (NaN), signed → 0x7FFFFFFF, NV; resp_valid 1 cycle after accept. rm=111 with frm=101 → resp_illegal=1, data 0.
5. 0xBF000000 (−0.5), rm=111, frm=010, signed → 0xFFFFFFFF, fflags 0x01. 0x00000001 (denormal) with RUP → 1, NX.
6. Two back-to-back cases:
   - Backpressure: hold resp_ready=0 for 5 cycles → resp_* stable, req_ready=0.
   - Flush: send 0x4E6E6B28 (1e9, k=4) and assert flush in the 2nd SHIFT cycle → IDLE next cycle, no response.
   - A subsequent request completes normally.
